// File: rtl/seq_mult16_pkg.sv
// Shared definitions for the seq_mult16 shift-add multiplier.
//   MULT_WIDTH : default operand width
//   state_e    : controller states (IDLE -> RUN -> DONE -> IDLE)
package seq_mult16_pkg;

  localparam int unsigned MULT_WIDTH = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_mult16_if.sv
// Request/result bundle of the seq_mult16 multiplier.
//   master : issues start/signed_op/a/b, observes busy/done/prod_lo/prod_hi/ovf
//   slave  : the multiplier side of the same signals
interface seq_mult16_if
  import seq_mult16_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
);

  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] prod_lo;
  logic [WIDTH-1:0] prod_hi;
  logic             ovf;

  modport master (
    output start, signed_op, a, b,
    input  busy, done, prod_lo, prod_hi, ovf
  );

  modport slave (
    input  start, signed_op, a, b,
    output busy, done, prod_lo, prod_hi, ovf
  );

endinterface

// File: rtl/seq_mult16_reg.sv
// register16: loadable register with synchronous active-high clear.
//   clk : clock        rst : synchronous clear to zero
//   en  : load enable  d   : data in        q : registered data out
module register16 #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en) q_d = d;
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/seq_mult16.sv
// seq_mult16: iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH,
// one partial product per clock, signed or unsigned operands.
//   clk  : clock            rst : synchronous active-high reset
//   bus  : slave side of seq_mult16_if
//          start/signed_op/a/b sampled in IDLE; busy high in RUN and DONE;
//          done is a one-cycle pulse; prod_lo/prod_hi/ovf hold the last result.
module seq_mult16
  import seq_mult16_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH,
  parameter int unsigned CNT_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  seq_mult16_if.slave  bus
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;
  logic               signed_q, signed_d;

  logic [2*WIDTH-1:0] acc_sum;
  logic [2*WIDTH-1:0] result;
  logic               res_en;
  logic               ovf_d;
  logic               last_iter;
  logic [WIDTH-1:0]   prod_lo_q, prod_hi_q;
  logic               ovf_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    signed_d = signed_q;
    res_en   = 1'b0;

    last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    acc_sum   = acc_q + (mcand_q[0] ? ({{WIDTH{1'b0}}, mplier_q} << cnt_q) : '0);

    // The final add and the sign fix-up share one edge, so the result is
    // formed from this cycle's sum rather than the accumulator register.
    result = neg_q ? -acc_sum : acc_sum;
    if (signed_q) ovf_d = (result[2*WIDTH-1:WIDTH] != {WIDTH{result[WIDTH-1]}});
    else          ovf_d = (result[2*WIDTH-1:WIDTH] != '0);

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d  = S_RUN;
          cnt_d    = '0;
          // Magnitudes are unsigned WIDTH-bit, so |most-negative| is exact.
          mcand_d  = (bus.signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
          mplier_d = (bus.signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;
          neg_d    = bus.signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          signed_d = bus.signed_op;
          acc_d    = '0;
        end
      end
      S_RUN: begin
        acc_d   = acc_sum;
        mcand_d = mcand_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (last_iter) begin
          state_d = S_DONE;
          res_en  = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      signed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      signed_q <= signed_d;
    end
  end

  register16 #(.W(WIDTH)) u_prod_lo (
    .clk (clk),
    .rst (rst),
    .en  (res_en),
    .d   (result[WIDTH-1:0]),
    .q   (prod_lo_q)
  );

  register16 #(.W(WIDTH)) u_prod_hi (
    .clk (clk),
    .rst (rst),
    .en  (res_en),
    .d   (result[2*WIDTH-1:WIDTH]),
    .q   (prod_hi_q)
  );

  register16 #(.W(1)) u_ovf (
    .clk (clk),
    .rst (rst),
    .en  (res_en),
    .d   (ovf_d),
    .q   (ovf_q)
  );

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = (state_q == S_DONE);
  assign bus.prod_lo = prod_lo_q;
  assign bus.prod_hi = prod_hi_q;
  assign bus.ovf     = ovf_q;

endmodule
